sr_write_ctrl: RTL and testbench
================================

Name: sr_write_ctrl

Overview:
Write-side controller for a WIDTH-bit bank of SR flip-flops built from enable-gated SR latches. Accepts a masked data-word write over a valid/ready handshake. Produces per-bit set/reset vectors, then one timed enable pulse with setup and hold margins. Guarantees set and reset are never both high on any bit, so the forbidden SR state cannot occur.

Parameters:
WIDTH, 8, number of SR flip-flops driven
SETUP_CYC, 1, cycles s/r are stable before en_out rises (min 1)
PULSE_CYC, 2, cycles en_out is high (min 1)
HOLD_CYC, 1, cycles s/r stay stable after en_out falls (min 1)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  write request present
req_ready  output  1  controller can accept a request
req_data  input  WIDTH  target bit values
req_mask  input  WIDTH  1 = write this bit, 0 = leave unchanged
s_out  output  WIDTH  set lines to bank
r_out  output  WIDTH  reset lines to bank
en_out  output  1  latch enable pulse to bank
q_in  input  WIDTH  bank q readback (used only with SR_VERIFY_EN)
done  output  1  one-cycle completion strobe
err  output  1  one-cycle readback-mismatch strobe, coincident with done

Behaviour:
- Reset (rst=1 at edge): state IDLE; s_out=0, r_out=0, en_out=0, done=0, err=0; req_ready=1 the cycle after. Reset mid-operation aborts immediately; en_out is low from the next cycle, and no done is produced.
- Handshake: a transfer happens when req_valid & req_ready at an edge. req_ready=1 only in IDLE. req_data/req_mask are registered at the transfer, so later input changes have no effect.
- Vectors: s = data & mask; r = ~data & mask. s & r is 0 on every bit in every cycle. Outside SETUP/PULSE/HOLD, s_out=r_out=0.
- FSM: IDLE -> SETUP (SETUP_CYC cycles, s/r driven, en_out=0) -> PULSE (PULSE_CYC cycles, en_out=1) -> HOLD (HOLD_CYC cycles, en_out=0, s/r held) -> [VERIFY] -> IDLE.
- done pulses high for one cycle on the cycle the FSM re-enters IDLE. A new request may be accepted in that same cycle (req_ready=1).
- Latency, accept edge to done: SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles (defaults: 5).
- Zero mask: IDLE -> IDLE with no SETUP/PULSE/HOLD. done pulses the cycle after accept; en_out never rises.
- A single down-counter of width clog2(max cycle param)+1 is reloaded on each state entry.

Optional Feature:
SR_VERIFY_EN
- Defined: a VERIFY state of one cycle follows HOLD. It samples q_in and asserts err with done if (q_in & mask) != (data & mask). Latency becomes +1 (defaults: 6).
- Undefined: no VERIFY state, q_in is ignored, and err is tied 0.

Decomposition:
- Shared include sr_defs.vh holds `define state encodings (IDLE, SETUP, PULSE, HOLD, VERIFY) and the default timing constants.
- One sub-module, sr_cyc_timer: a loadable down-counter with a zero flag, used for all phase timing.

Test Plan:
- Defaults, data=8'hA5, mask=8'hFF -> s_out=A5, r_out=5A from cycle 1; en_out high cycles 2-3; done at cycle 5; s_out & r_out == 0 throughout.
- mask=8'h0F, data=8'hF3 -> s_out=03, r_out=0C; upper nibble of bank unchanged after done.
- mask=0 -> done one cycle after accept; en_out stays 0; s_out=r_out=0.
- Back-to-back requests with req_valid held high -> second accepted in the done cycle; second SETUP starts the next cycle; no gap in en_out timing.
- rst asserted during PULSE -> en_out=0, s_out=r_out=0 next cycle; no done; req_ready=1.
- SR_VERIFY_EN, q_in forced to 8'h00 with data=8'hFF, mask=8'hFF -> err=1 and done=1 at cycle 6; with q_in=8'hFF -> err=0.

Source files
------------

// File: rtl/sr_write_ctrl_pkg.sv
// rtl/sr_write_ctrl_pkg.sv - state constants, timing defaults and helpers for sr_write_ctrl
package sr_write_ctrl_pkg;
`include "sr_defs.vh"

  localparam logic [2:0] ST_IDLE   = `SR_ST_IDLE;
  localparam logic [2:0] ST_SETUP  = `SR_ST_SETUP;
  localparam logic [2:0] ST_PULSE  = `SR_ST_PULSE;
  localparam logic [2:0] ST_HOLD   = `SR_ST_HOLD;
  localparam logic [2:0] ST_VERIFY = `SR_ST_VERIFY;

  localparam int SETUP_CYC_DEF = `SR_SETUP_CYC_DEF;
  localparam int PULSE_CYC_DEF = `SR_PULSE_CYC_DEF;
  localparam int HOLD_CYC_DEF  = `SR_HOLD_CYC_DEF;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sr_defs.vh
// rtl/sr_defs.vh - shared state encodings and default timing for the SR write controller
`ifndef SR_DEFS_VH
`define SR_DEFS_VH

`define SR_ST_IDLE    3'd0
`define SR_ST_SETUP   3'd1
`define SR_ST_PULSE   3'd2
`define SR_ST_HOLD    3'd3
`define SR_ST_VERIFY  3'd4

`define SR_SETUP_CYC_DEF 1
`define SR_PULSE_CYC_DEF 2
`define SR_HOLD_CYC_DEF  1

`endif

// File: rtl/sr_write_ctrl_cyc_timer.sv
// rtl/sr_write_ctrl_cyc_timer.sv - loadable down-counter with zero flag for phase timing
//
// Module sr_cyc_timer
//   clk      : clock
//   rst      : synchronous active-high reset (count -> 0)
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value loaded; a phase of N cycles loads N-1
//   zero     : count is zero (current phase ends this cycle)
module sr_cyc_timer
  import sr_write_ctrl_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sr_write_ctrl.sv
// rtl/sr_write_ctrl.sv - masked write controller for an enable-gated SR flip-flop bank
//
// Optional feature macro: SR_VERIFY_EN (adds a one-cycle q_in readback check).
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset; aborts any write in progress
//   req_valid : write request present
//   req_ready : high only in IDLE
//   req_data  : target bit values
//   req_mask  : 1 = write bit, 0 = leave bit unchanged
//   s_out     : set lines (data & mask) during SETUP/PULSE/HOLD, else 0
//   r_out     : reset lines (~data & mask) during SETUP/PULSE/HOLD, else 0
//   en_out    : latch enable, high for the PULSE phase only
//   q_in      : bank readback, sampled in VERIFY when SR_VERIFY_EN is defined
//   done      : one-cycle strobe on re-entry to IDLE
//   err       : one-cycle readback-mismatch strobe, coincident with done
module sr_write_ctrl
  import sr_write_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int HOLD_CYC  = HOLD_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] req_mask,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  output logic             en_out,
  input  logic [WIDTH-1:0] q_in,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC)) + 1;
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  logic [2:0]       state;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] mask_r;
  logic             tmr_load;
  logic [CW-1:0]    tmr_val;
  logic             tmr_zero;
  logic             accept;
  logic             drive;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  // s and r are derived from the same registered mask with complementary data,
  // so they can never both be high on a bit; gating by phase keeps the bank
  // inputs quiet whenever en_out could not be near a transition.
  assign drive  = (state == ST_SETUP) || (state == ST_PULSE) || (state == ST_HOLD);
  assign s_out  = drive ? (data_r & mask_r) : '0;
  assign r_out  = drive ? (~data_r & mask_r) : '0;
  assign en_out = (state == ST_PULSE);

  // The timer is reloaded on every entry into a timed phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = SETUP_LD;
    case (state)
      ST_IDLE: begin
        tmr_load = accept && (req_mask != '0);
        tmr_val  = SETUP_LD;
      end
      ST_SETUP: begin
        tmr_load = tmr_zero;
        tmr_val  = PULSE_LD;
      end
      ST_PULSE: begin
        tmr_load = tmr_zero;
        tmr_val  = HOLD_LD;
      end
      default: begin
        tmr_load = 1'b0;
        tmr_val  = SETUP_LD;
      end
    endcase
  end

  sr_cyc_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      data_r <= '0;
      mask_r <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            data_r <= req_data;
            mask_r <= req_mask;
            // An empty mask writes nothing, so skip straight to completion.
            if (req_mask == '0) begin
              done <= 1'b1;
            end else begin
              state <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (tmr_zero) state <= ST_PULSE;
        end
        ST_PULSE: begin
          if (tmr_zero) state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (tmr_zero) begin
`ifdef SR_VERIFY_EN
            state <= ST_VERIFY;
`else
            state <= ST_IDLE;
            done  <= 1'b1;
`endif
          end
        end
`ifdef SR_VERIFY_EN
        ST_VERIFY: begin
          state <= ST_IDLE;
          done  <= 1'b1;
          err   <= |((q_in ^ data_r) & mask_r);
        end
`endif
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef SR_VERIFY_EN
  logic unused_q;
  assign unused_q = ^q_in;
`endif

endmodule

// File: tb/tb_sr_write_ctrl.sv
// tb/tb_sr_write_ctrl.sv - scoreboard bench for sr_write_ctrl
module tb_sr_write_ctrl;

  localparam int SETUP_CYC = 1;
  localparam int PULSE_CYC = 2;
  localparam int HOLD_CYC  = 1;
`ifdef SR_VERIFY_EN
  localparam int LAT = SETUP_CYC + PULSE_CYC + HOLD_CYC + 2;
`else
  localparam int LAT = SETUP_CYC + PULSE_CYC + HOLD_CYC + 1;
`endif

  typedef struct {
    logic [7:0] s;
    logic [7:0] r;
    logic [7:0] bank;
    int         lat;
    int         en;
    logic       err;
  } item_t;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic [7:0] req_mask;
  logic [7:0] s_out;
  logic [7:0] r_out;
  logic       en_out;
  logic [7:0] q_in;
  logic       done;
  logic       err;

  logic [7:0] bank;
  logic       q_force;
  logic [7:0] q_val;

  item_t sb[$];
  int    accept_q[$];
  int    acc_log[$];
  int    acc_total;
  int    cyc;
  int    en_cnt;
  int    checks;
  int    failures;

  assign q_in = q_force ? q_val : bank;

  sr_write_ctrl #(
    .WIDTH     (8),
    .SETUP_CYC (SETUP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_mask  (req_mask),
    .s_out     (s_out),
    .r_out     (r_out),
    .en_out    (en_out),
    .q_in      (q_in),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: got event expected none (cycle %0d)", nm, cyc);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst && req_valid && req_ready) begin
      accept_q.push_back(cyc);
      acc_log.push_back(cyc);
      acc_total++;
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    item_t it;
    int    a;
    if (rst) begin
      en_cnt = 0;
    end else begin
      if ((s_out != 0) || (r_out != 0) || en_out) begin
        check("s_and_r_exclusive", int'(s_out & r_out), 0);
        if (sb.size() == 0 || accept_q.size() == 0) begin
          fail("spurious_drive");
        end else begin
          check("s_out", int'(s_out), int'(sb[0].s));
          check("r_out", int'(r_out), int'(sb[0].r));
          if (en_out) begin
            en_cnt++;
            if (en_cnt == 1) check("en_start_cycle", cyc - accept_q[0] + 1, SETUP_CYC + 1);
          end
        end
      end
      if (err && !done) fail("err_without_done");
      if (done) begin
        if (sb.size() == 0 || accept_q.size() == 0) begin
          fail("unexpected_done");
        end else begin
          it = sb.pop_front();
          a  = accept_q.pop_front();
          check("latency", cyc - a + 1, it.lat);
          check("en_cycles", en_cnt, it.en);
          check("err", int'(err), int'(it.err));
          check("bank", int'(bank), int'(it.bank));
        end
        en_cnt = 0;
      end
      if (en_out) bank = (bank & ~r_out) | s_out;
    end
  end

  task automatic send(input logic [7:0] d, input logic [7:0] m, input logic [7:0] eb,
                      input logic ee, input bit hold_valid);
    item_t it;
    int    n0;
    it.s    = d & m;
    it.r    = ~d & m;
    it.bank = eb;
    it.lat  = (m == 8'h00) ? 1 : LAT;
    it.en   = (m == 8'h00) ? 0 : PULSE_CYC;
    it.err  = ee;
    sb.push_back(it);
    req_data  = d;
    req_mask  = m;
    req_valid = 1'b1;
    n0 = acc_total;
    for (int i = 0; i < 60 && acc_total == n0; i++) begin
      @(posedge clk);
      #1;
    end
    if (acc_total == n0) fail("accept_timeout");
    if (!hold_valid) req_valid = 1'b0;
    // Scramble inputs after the transfer; the DUT must have registered them.
    req_data = ~d;
    req_mask = ~m;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      fail("done_timeout");
      sb.delete();
      accept_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    acc_total = 0;
    en_cnt    = 0;
    bank      = 8'h00;
    q_force   = 1'b0;
    q_val     = 8'h00;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_data  = 8'h00;
    req_mask  = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", int'(req_ready), 1);
    check("reset_en_out", int'(en_out), 0);
    check("reset_s_out", int'(s_out), 0);
    check("reset_r_out", int'(r_out), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(8'hA5, 8'hFF, 8'hA5, 1'b0, 1'b0);
    wait_idle();
    send(8'hF3, 8'h0F, 8'hA3, 1'b0, 1'b0);
    wait_idle();
    send(8'h5A, 8'h00, 8'hA3, 1'b0, 1'b0);
    wait_idle();

    send(8'h0F, 8'hF0, 8'h03, 1'b0, 1'b1);
    send(8'hC0, 8'hC0, 8'hC3, 1'b0, 1'b0);
    if (acc_log.size() >= 2)
      check("b2b_accept_gap", acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2], LAT);
    else
      fail("b2b_accept_missing");
    wait_idle();

    send(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        if (en_out) seen = 1'b1;
        else begin
          @(posedge clk);
          #1;
        end
      end
      check("abort_reached_pulse", int'(seen), 1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    accept_q.delete();
    check("abort_en_out", int'(en_out), 0);
    check("abort_s_out", int'(s_out), 0);
    check("abort_r_out", int'(r_out), 0);
    check("abort_done", int'(done), 0);
    check("abort_req_ready", int'(req_ready), 1);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;

`ifdef SR_VERIFY_EN
    q_force = 1'b1;
    q_val   = 8'h00;
    send(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_idle();
    q_val   = 8'hFF;
    send(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    wait_idle();
    q_force = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
